// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: a circular buffer of {pc, instr} entries.
// in_stall and out_valid decode from registered count only; flush clears everything.
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_stall,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [63:0]     mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  assign in_stall  = (count_q == CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid && !in_stall && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Head data is gated to zero (pc 0 / nop) whenever the queue is empty.
  assign out_pc    = out_valid ? mem_q[head_q][63:32] : 32'h0000_0000;
  assign out_instr = out_valid ? mem_q[head_q][31:0]  : 32'h0000_0000;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && reset) begin
      mem_q[tail_q] <= {in_pc, in_instr};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=4): directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;

  int checks;
  int failures;

  logic [63:0] model_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .in_stall (in_stall),
    .flush    (flush),
    .out_valid(out_valid),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .out_ready(out_ready),
    .count    (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  function automatic logic [31:0] exp_pc();
    if (model_q.size() == 0) return 32'h0;
    return model_q[0][63:32];
  endfunction

  function automatic logic [31:0] exp_instr();
    if (model_q.size() == 0) return 32'h0;
    return model_q[0][31:0];
  endfunction

  function automatic logic [2:0] exp_count();
    return 3'(model_q.size());
  endfunction

  // One clock edge: model applies queue rules to the inputs seen at the edge.
  task automatic tick();
    bit do_push;
    bit do_pop;
    @(posedge clk);
    if (!reset) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() > 0) && out_ready;
      do_push = in_valid && (model_q.size() < DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({in_pc, in_instr});
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 32'h0000_3000, 1'b1, 1'b0);
    tick();
    tick();
    checks += 5;
    if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (in_stall !== 1'b0) begin failures++; $display("FAIL reset_in_stall got=%b exp=0", in_stall); end
    if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    tick();
    checks++;
    if (count !== 3'd0) begin failures++; $display("FAIL reset_release_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_3000 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    checks += 3;
    if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
    if (in_stall !== 1'b1) begin failures++; $display("FAIL fill_in_stall got=%b exp=1", in_stall); end
    if (out_pc !== 32'h0000_3000) begin failures++; $display("FAIL fill_head got=%h exp=3000", out_pc); end
    drive(1'b1, 32'h0000_3010, 1'b0, 1'b0);
    tick();
    checks += 2;
    if (count !== 3'd4) begin failures++; $display("FAIL fill_fifth_count got=%0d exp=4", count); end
    if (out_pc !== 32'h0000_3000) begin failures++; $display("FAIL fill_fifth_head got=%h exp=3000", out_pc); end
  endtask

  task automatic test_drain();
    logic [31:0] pc;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h0000_3000 + 32'(4 * i);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_valid%0d got=%b exp=1", i, out_valid); end
      if (out_pc !== pc) begin failures++; $display("FAIL drain_pc%0d got=%h exp=%h", i, out_pc, pc); end
      if (out_instr !== instr_of(pc)) begin
        failures++; $display("FAIL drain_instr%0d got=%h exp=%h", i, out_instr, instr_of(pc));
      end
      tick();
    end
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_end_valid got=%b exp=0", out_valid); end
    if (out_pc !== 32'h0) begin failures++; $display("FAIL drain_end_pc got=%h exp=0", out_pc); end
    if (in_stall !== 1'b0) begin failures++; $display("FAIL drain_end_stall got=%b exp=0", in_stall); end
    if (count !== 3'd0) begin failures++; $display("FAIL drain_end_count got=%0d exp=0", count); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    for (int i = 0; i < 10; i++) begin
      pc = 32'h0000_3000 + 32'(4 * i);
      drive(1'b1, pc, 1'b1, 1'b0);
      tick();
      checks += 3;
      if (count !== 3'd1) begin failures++; $display("FAIL stream_count%0d got=%0d exp=1", i, count); end
      if (out_pc !== pc) begin failures++; $display("FAIL stream_pc%0d got=%h exp=%h", i, out_pc, pc); end
      if (out_instr !== instr_of(pc)) begin
        failures++; $display("FAIL stream_instr%0d got=%h exp=%h", i, out_instr, instr_of(pc));
      end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_end_valid got=%b exp=0", out_valid); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_3100 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    drive(1'b1, 32'h0000_4000, 1'b1, 1'b1);
    tick();
    checks += 3;
    if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    if (in_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", in_stall); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_after_valid got=%b exp=0", out_valid); end
    if (out_pc !== 32'h0) begin failures++; $display("FAIL flush_after_pc got=%h exp=0", out_pc); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_full_pop();
    logic [31:0] pc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_5000 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h0000_5010, 1'b1, 1'b0);
    tick();
    checks += 3;
    if (count !== 3'd3) begin failures++; $display("FAIL fullpop_count got=%0d exp=3", count); end
    if (in_stall !== 1'b0) begin failures++; $display("FAIL fullpop_stall got=%b exp=0", in_stall); end
    if (out_pc !== 32'h0000_5004) begin failures++; $display("FAIL fullpop_head got=%h exp=5004", out_pc); end
    for (int i = 1; i < 4; i++) begin
      pc = 32'h0000_5000 + 32'(4 * i);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      checks++;
      if (out_pc !== pc) begin failures++; $display("FAIL fullpop_drain%0d got=%h exp=%h", i, out_pc, pc); end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fullpop_end_valid got=%b exp=0", out_valid); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0000_6000 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd2) begin failures++; $display("FAIL areset_pre_count got=%0d exp=2", count); end
    #3 reset = 1'b0;
    model_q.delete();
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
    if (count !== 3'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count); end
    if (out_pc !== 32'h0) begin failures++; $display("FAIL areset_pc got=%h exp=0", out_pc); end
    #2 reset = 1'b1;
    drive(1'b1, 32'h0000_3000, 1'b0, 1'b0);
    tick();
    checks += 3;
    if (count !== 3'd1) begin failures++; $display("FAIL areset_push_count got=%0d exp=1", count); end
    if (out_pc !== 32'h0000_3000) begin failures++; $display("FAIL areset_push_pc got=%h exp=3000", out_pc); end
    if (out_instr !== instr_of(32'h0000_3000)) begin
      failures++; $display("FAIL areset_push_instr got=%h exp=%h", out_instr, instr_of(32'h0000_3000));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 19) == 0));
      tick();
      checks += 5;
      if (count !== exp_count()) begin
        failures++; $display("FAIL rand_count%0d got=%0d exp=%0d", i, count, exp_count());
      end
      if (out_valid !== (model_q.size() != 0)) begin
        failures++; $display("FAIL rand_valid%0d got=%b exp=%b", i, out_valid, model_q.size() != 0);
      end
      if (in_stall !== (model_q.size() == DEPTH)) begin
        failures++; $display("FAIL rand_stall%0d got=%b exp=%b", i, in_stall, model_q.size() == DEPTH);
      end
      if (out_pc !== exp_pc()) begin
        failures++; $display("FAIL rand_pc%0d got=%h exp=%h", i, out_pc, exp_pc());
      end
      if (out_instr !== exp_instr()) begin
        failures++; $display("FAIL rand_instr%0d got=%h exp=%h", i, out_instr, exp_instr());
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_full_pop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
